// File: rtl/mem_adr_pkg.sv
// Shared types and default constants for the memory address sequencer.
// Optional feature macro used by the top: MEM_ADR_MISALIGN_CHECK_EN.
package mem_adr_pkg;

    localparam int AW_DEF         = 32;
    localparam int BURST_MAX_DEF  = 4;
    localparam int BEAT_BYTES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Counter width for a burst length of n beats; a single-beat build still needs one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_adr_beat_ctr.sv
// Beat counters for one burst: beat_idx counts beats issued, beats_left counts beats remaining.
module mem_adr_beat_ctr
    import mem_adr_pkg::*;
#(
    parameter int LW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [LW-1:0] load_val,
    input  logic          dec,
    input  logic          clr,
    output logic [LW-1:0] beat_idx,
    output logic [LW-1:0] beats_left
);

    // clr wins over load, load wins over dec.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_idx   <= '0;
            beats_left <= '0;
        end else if (clr) begin
            beat_idx   <= '0;
            beats_left <= '0;
        end else if (load) begin
            beat_idx   <= '0;
            beats_left <= load_val;
        end else if (dec) begin
            beat_idx   <= beat_idx + 1'b1;
            beats_left <= beats_left - 1'b1;
        end
    end

endmodule

// File: rtl/mem_adr_seq.sv
// Memory address sequencer: latches pc or alu_out_r on start and walks a burst of beats.
// Defining MEM_ADR_MISALIGN_CHECK_EN turns misaligned bases into an immediate misalign completion.
module mem_adr_seq
    import mem_adr_pkg::*;
#(
    parameter int  AW         = AW_DEF,
    parameter int  BURST_MAX  = BURST_MAX_DEF,
    parameter int  BEAT_BYTES = BEAT_BYTES_DEF,
    localparam int LW         = clog2_min1(BURST_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          IDSel,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] alu_out_r,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          mem_ack,
    output logic          mem_req,
    output logic [AW-1:0] mem_adr,
    output logic          busy,
    output logic          done,
    output logic          misalign,
    output state_t        state_dbg
);

    // Handshake: a beat transfers on a rising edge where mem_req and mem_ack are both 1;
    // mem_req never drops and mem_adr never changes while a beat waits for mem_ack.

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] base_q;
    logic [AW-1:0] src;
    logic [AW-1:0] offset;
    logic [LW-1:0] beat_idx;
    logic [LW-1:0] beats_left;
    logic          ctr_load;
    logic          ctr_dec;
    logic          ctr_clr;
    logic          accept;
    logic          start_mis;

    assign src       = IDSel ? alu_out_r : pc;
    assign offset    = AW'(beat_idx) * AW'(BEAT_BYTES);
    assign accept    = (state_q == IDLE) && start;
    assign state_dbg = state_q;

`ifdef MEM_ADR_MISALIGN_CHECK_EN
    logic mis_q;

    assign start_mis = (src % AW'(BEAT_BYTES)) != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= start_mis;
        end
    end

    assign misalign = (state_q == FIN) && mis_q;
`else
    assign start_mis = 1'b0;
    assign misalign  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                base_q <= src;
            end
        end
    end

    mem_adr_beat_ctr #(
        .LW(LW)
    ) u_beat_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (ctr_load),
        .load_val  (len),
        .dec       (ctr_dec),
        .clr       (ctr_clr),
        .beat_idx  (beat_idx),
        .beats_left(beats_left)
    );

    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        mem_adr  = base_q + offset;
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
        ctr_clr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Zero-latency pass-through of the selected source while idle.
                mem_adr = src;
                if (start) begin
                    ctr_load = 1'b1;
                    state_d  = start_mis ? FIN : REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (mem_ack) begin
                    if (beats_left == '0) begin
                        state_d = FIN;
                    end else begin
                        ctr_dec = 1'b1;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                ctr_clr = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_adr_seq.sv
// Directed and randomized bench for mem_adr_seq against a queue-based address model.
module tb_mem_adr_seq;
  import mem_adr_pkg::*;

  localparam int AW = 32;
  localparam int BB = 4;
  localparam int LW = clog2_min1(4);

  logic          clk;
  logic          rst;
  logic          IDSel;
  logic [AW-1:0] pc;
  logic [AW-1:0] alu_out_r;
  logic          start;
  logic [LW-1:0] len;
  logic          mem_ack;
  logic          mem_req;
  logic [AW-1:0] mem_adr;
  logic          busy;
  logic          done;
  logic          misalign;
  state_t        state_dbg;

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  mem_adr_seq #(
    .AW(AW),
    .BURST_MAX(4),
    .BEAT_BYTES(BB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .IDSel    (IDSel),
    .pc       (pc),
    .alu_out_r(alu_out_r),
    .start    (start),
    .len      (len),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_adr  (mem_adr),
    .busy     (busy),
    .done     (done),
    .misalign (misalign),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a falling edge with the DUT idle; returns in the idle cycle right after done.
  task automatic run_burst(input bit sel, input logic [AW-1:0] b, input int l,
                           input bit rnd_ack, input int stall_beat, input int stall_n,
                           input bit chk_cycles);
    int beat;
    int stalls;
    int cyc;
    bit ack;
    logic [AW-1:0] e;
    exp_q = {};
    for (int k = 0; k <= l; k++) begin
      e = b + AW'(k * BB);
      exp_q.push_back(e);
    end
    IDSel = sel;
    if (sel) begin
      alu_out_r = b;
      pc        = $urandom;
    end else begin
      pc        = b;
      alu_out_r = $urandom;
    end
    len     = l[LW-1:0];
    start   = 1'b1;
    mem_ack = 1'b0;
    #1;
    chk("idle_adr", mem_adr, b);
    @(negedge clk);
    beat   = 0;
    stalls = 0;
    cyc    = 0;
    while (exp_q.size() > 0 && cyc < 64) begin
      if (rnd_ack) begin
        ack = 1'($urandom_range(0, 1));
      end else if (beat == stall_beat && stalls < stall_n) begin
        ack = 1'b0;
        stalls++;
      end else begin
        ack = 1'b1;
      end
      mem_ack   = ack;
      start     = 1'($urandom_range(0, 1));
      IDSel     = 1'($urandom_range(0, 1));
      pc        = $urandom;
      alu_out_r = $urandom;
      #1;
      chk("beat_req", mem_req, 1'b1);
      chk("beat_busy", busy, 1'b1);
      chk("beat_done", done, 1'b0);
      chk("beat_adr", mem_adr, exp_q[0]);
      @(negedge clk);
      cyc++;
      if (ack) begin
        void'(exp_q.pop_front());
        beat++;
      end
    end
    chk("burst_budget", exp_q.size(), 0);
    mem_ack = 1'b0;
    start   = 1'($urandom_range(0, 1));
    #1;
    chk("fin_done", done, 1'b1);
    chk("fin_busy", busy, 1'b0);
    chk("fin_req", mem_req, 1'b0);
    chk("fin_misalign", misalign, 1'b0);
    if (chk_cycles) begin
      chk("burst_cycles", cyc, l + 1 + stall_n);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("post_state", state_dbg, IDLE);
    chk("post_done", done, 1'b0);
    chk("post_busy", busy, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] rb;
    rst       = 1'b1;
    IDSel     = 1'b0;
    pc        = '0;
    alu_out_r = '0;
    start     = 1'b0;
    len       = '0;
    mem_ack   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", state_dbg, IDLE);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    rst = 1'b0;

    // Idle pass-through of both sources
    @(negedge clk);
    IDSel = 1'b0;
    pc    = 32'h0040_0000;
    #1;
    chk("idle_pc", mem_adr, 32'h0040_0000);
    IDSel     = 1'b1;
    alu_out_r = 32'h1000_0010;
    #1;
    chk("idle_alu", mem_adr, 32'h1000_0010);

    // Basic 4-beat burst, always acked; then back-to-back stalled burst, wrap, single beat
    @(negedge clk);
    run_burst(1'b1, 32'h0000_0100, 3, 1'b0, -1, 0, 1'b1);
    run_burst(1'b1, 32'h0000_0100, 3, 1'b0, 1, 2, 1'b1);
    run_burst(1'b0, 32'hFFFF_FFF8, 3, 1'b0, -1, 0, 1'b1);
    run_burst(1'b0, 32'h0000_2000, 0, 1'b0, 0, 3, 1'b1);

    // Reset during beat 2: abandoned with no done, next start accepted
    @(negedge clk);
    IDSel     = 1'b1;
    alu_out_r = 32'h0000_0200;
    len       = 2'd3;
    start     = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_adr", mem_adr, 32'h0000_0208);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", mem_req, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_state", state_dbg, IDLE);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_nodone", done, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_nodone", done, 1'b0);
    run_burst(1'b1, 32'h0000_0300, 1, 1'b0, -1, 0, 1'b1);

    // Misaligned base
`ifdef MEM_ADR_MISALIGN_CHECK_EN
    IDSel     = 1'b1;
    alu_out_r = 32'h0000_0102;
    len       = 2'd3;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("mis_req", mem_req, 1'b0);
    chk("mis_done", done, 1'b1);
    chk("mis_flag", misalign, 1'b1);
    @(negedge clk);
    chk("mis_idle", state_dbg, IDLE);
`else
    run_burst(1'b1, 32'h0000_0102, 3, 1'b0, -1, 0, 1'b1);
`endif

    // Randomized bursts with random acks and random sources
    for (int n = 0; n < 25; n++) begin
      rb = $urandom;
      rb = rb & ~32'(BB - 1);
      run_burst(1'($urandom_range(0, 1)), rb, $urandom_range(0, 3), 1'b1, -1, 0, 1'b0);
    end

    if (bad == 0) begin
      $display("PASS: test done: total=%0d bad=%0d", total, bad);
    end else begin
      $display("FAIL: test done: total=%0d bad=%0d", total, bad);
    end
    $finish;
  end

endmodule
